mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the core's single memory port between the instruction-fetch channel and the load/store data channel.
- The control unit issues fetch and store requests; this block captures each request into a per-channel pending slot, arbitrates, and runs one outstanding memory transaction at a time.
- It routes the response back to the owning channel and enforces a response timeout.

Parameters:
ADDR_WIDTH, 32, address width on all channels
DATA_WIDTH, 32, data width; must be a multiple of 8
TIMEOUT_CYCLES, 255, cycles in REQ+WAIT before a forced error response; 0 disables the timeout

Ports:
clk  input  1  core clock
rst  input  1  asynchronous, active-low reset
i_req_valid  input  1  instruction fetch request
i_req_ready  output  1  instruction slot free
i_req_addr  input  ADDR_WIDTH  fetch address
i_resp_valid  output  1  one-cycle fetch response pulse
i_resp_data  output  DATA_WIDTH  fetched instruction
i_resp_error  output  1  qualifies i_resp_valid; timeout occurred
d_req_valid  input  1  data request
d_req_ready  output  1  data slot free
d_req_addr  input  ADDR_WIDTH  data address
d_req_write  input  1  1 = store, 0 = load
d_req_wdata  input  DATA_WIDTH  store data
d_req_wstrb  input  DATA_WIDTH/8  byte strobes
d_resp_valid  output  1  one-cycle data response pulse; also fires for store acks
d_resp_data  output  DATA_WIDTH  load data
d_resp_error  output  1  qualifies d_resp_valid; timeout occurred
m_req_valid  output  1  memory request
m_req_ready  input  1  memory accepts request
m_addr  output  ADDR_WIDTH  memory address
m_write  output  1  memory write
m_wdata  output  DATA_WIDTH  memory write data
m_wstrb  output  DATA_WIDTH/8  memory byte strobes
m_resp_valid  input  1  memory response
m_resp_data  input  DATA_WIDTH  memory read data

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to IDLE; both pending slots are cleared.
  - All outputs are 0 except i_req_ready = d_req_ready = 1.
  - last_grant = INST, so data wins the first tie.
  - m_req_valid drops immediately, even mid-transaction.
- Capture:
  - x_req_ready = !x_pending.
  - On x_req_valid && x_req_ready at a clock edge, the request fields are registered and x_pending is set.
  - Requests may be single-cycle pulses.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - If no slot is pending, stay in IDLE.
  - If exactly one slot is pending, grant it.
  - If both are pending, grant the channel not equal to last_grant (round-robin).
  - On the grant edge: register m_addr, m_write, m_wdata and m_wstrb from the granted slot, set m_req_valid = 1, update last_grant, go to REQ.
  - Instruction grants drive m_write = 0 and m_wstrb = 0.
- REQ: hold m_req_valid and all fields stable until m_req_ready. On m_req_valid && m_req_ready, clear m_req_valid and go to WAIT.
- WAIT:
  - On m_resp_valid, register the response into the granted channel.
  - x_resp_valid = 1 for exactly one cycle; x_resp_data = m_resp_data; x_resp_error = 0.
  - Clear x_pending and go to IDLE.
- Latency:
  - Capture at edge k: m_req_valid is first high after edge k+1.
  - m_resp_valid at edge j: x_resp_valid is high after edge j, for one cycle.
  - x_req_ready is high again after edge j; the next arbitration occurs at edge j+1.
- Timeout counter:
  - Cleared on entry to REQ; increments each cycle in REQ or WAIT; saturates.
  - At count == TIMEOUT_CYCLES-1 with no m_resp_valid: pulse x_resp_valid with x_resp_error = 1 and x_resp_data = 0, clear m_req_valid and x_pending, go to IDLE.
  - If m_resp_valid arrives in the same cycle as the timeout, the normal response wins.
- m_resp_valid outside WAIT (e.g. a late response after a timeout) is ignored.
- A new capture on the same edge as a grant is visible to arbitration only in the next IDLE cycle. There is no same-cycle bypass.
- The non-granted slot stays pending and captured; its ready stays low.
- Stores and loads are treated identically; d_resp_data for a store equals m_resp_data and is don't-care to the requester.

Decomposition:
- Shared header copperv_h.v gets:
  - ARB_STATE_WIDTH and ARB_STATE_IDLE/REQ/WAIT
  - ARB_GRANT_INST/DATA
- One natural sub-module, arb_req_slot:
  - The per-channel capture register plus pending flag and ready.
  - Instantiated twice; the instruction instance has write/wstrb tied to 0.
- The FSM, round-robin and timeout logic stay in mem_arbiter.

Test Plan:
- Single fetch: i_req_addr=0x100 pulse, m_req_ready=1, m_resp_data=0x00500093 two cycles later -> m_addr=0x100, m_write=0; i_resp_valid one cycle with data 0x00500093, error=0; d_resp_valid never asserted.
- Tie round-robin: both channels request on the same edge (i 0x200, d write 0x8000 wdata 0xDEADBEEF wstrb 0xF) -> data granted first (m_write=1), instruction second; next tie grants instruction first.
- Backpressure: m_req_ready low for 5 cycles -> m_req_valid and m_addr/m_wdata held stable for all 5 cycles; one transaction only.
- Timeout: TIMEOUT_CYCLES=8, m_req_ready=1, no response -> d_resp_valid with d_resp_error=1 and data 0 exactly 8 cycles after REQ entry; a response arriving at cycle 10 is ignored.
- Simultaneous timeout and response: m_resp_valid on cycle 7 with TIMEOUT_CYCLES=8 -> normal response with error=0.
- Reset mid-WAIT: rst low asynchronously -> m_req_valid=0 and both readies=1 without waiting for a clock; no resp pulse; a subsequent fetch completes normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE / REQ / WAIT)
//   arb_grant_t : channel owning the current memory transaction
//   rr_pick     : chooses the channel to grant from the two pending flags
package mem_arbiter_pkg;

    localparam int ARB_STATE_WIDTH = 2;

    typedef enum logic [ARB_STATE_WIDTH-1:0] {
        ARB_STATE_IDLE = 2'd0,
        ARB_STATE_REQ  = 2'd1,
        ARB_STATE_WAIT = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_GRANT_INST = 1'b0,
        ARB_GRANT_DATA = 1'b1
    } arb_grant_t;

    // A single pending channel wins outright; on a tie the channel that did
    // not win last time is chosen.
    function automatic arb_grant_t rr_pick(input logic i_pend, input logic d_pend,
                                           input arb_grant_t last);
        if (i_pend && d_pend)
            return (last == ARB_GRANT_INST) ? ARB_GRANT_DATA : ARB_GRANT_INST;
        else if (d_pend)
            return ARB_GRANT_DATA;
        else
            return ARB_GRANT_INST;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_req_slot.sv
// Per-channel request capture slot.
// Registers one request and holds it until the arbiter clears it after the
// channel's response. ready is simply the inverse of the pending flag.
//   clk, rst         : clock, async active-low reset
//   req_valid/ready  : requester handshake
//   req_addr/write/wdata/wstrb : request fields from the requester
//   clear            : arbiter finished this channel's transaction
//   pending, addr, write, wdata, wstrb : captured request
module arb_req_slot #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic                    req_write,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    input  logic                    clear,
    output logic                    pending,
    output logic [ADDR_WIDTH-1:0]   addr,
    output logic                    write,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb
);

    assign req_ready = !pending;

    // clear and capture cannot coincide: ready is low while a transaction
    // for this channel is outstanding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= 1'b0;
            addr    <= '0;
            write   <= 1'b0;
            wdata   <= '0;
            wstrb   <= '0;
        end else if (req_valid && !pending) begin
            pending <= 1'b1;
            addr    <= req_addr;
            write   <= req_write;
            wdata   <= req_wdata;
            wstrb   <= req_wstrb;
        end else if (clear) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the instruction-fetch and load/store
// channels. Each channel has a capture slot; one memory transaction is
// outstanding at a time, responses are routed to the owning channel, and a
// stuck transaction is closed with an error response after TIMEOUT_CYCLES.
//   clk, rst                : clock, async active-low reset
//   i_req_* / i_resp_*      : instruction fetch channel
//   d_req_* / d_resp_*      : load/store channel
//   m_*                     : shared memory port
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no transaction; grant a pending slot (round-robin on tie)
// REQ   | m_req_valid high, fields frozen, waiting for m_req_ready
// WAIT  | request accepted, waiting for m_resp_valid
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_req_valid,
    output logic                    i_req_ready,
    input  logic [ADDR_WIDTH-1:0]   i_req_addr,
    output logic                    i_resp_valid,
    output logic [DATA_WIDTH-1:0]   i_resp_data,
    output logic                    i_resp_error,
    input  logic                    d_req_valid,
    output logic                    d_req_ready,
    input  logic [ADDR_WIDTH-1:0]   d_req_addr,
    input  logic                    d_req_write,
    input  logic [DATA_WIDTH-1:0]   d_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_req_wstrb,
    output logic                    d_resp_valid,
    output logic [DATA_WIDTH-1:0]   d_resp_data,
    output logic                    d_resp_error,
    output logic                    m_req_valid,
    input  logic                    m_req_ready,
    output logic [ADDR_WIDTH-1:0]   m_addr,
    output logic                    m_write,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    input  logic                    m_resp_valid,
    input  logic [DATA_WIDTH-1:0]   m_resp_data
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_WIDTH  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] TMO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    arb_state_t state, state_next;
    arb_grant_t last_grant, grant, grant_sel;
    logic [CNT_WIDTH-1:0] tmo_cnt;
    logic do_grant, do_resp, do_timeout, timeout_hit, clr_i, clr_d;

    logic                  i_pend, d_pend, i_wr_q, d_wr_q;
    logic [ADDR_WIDTH-1:0] i_addr_q, d_addr_q;
    logic [DATA_WIDTH-1:0] i_wdata_q, d_wdata_q;
    logic [STRB_WIDTH-1:0] i_wstrb_q, d_wstrb_q;

    // Fetches never write; tying the fields here makes the grant mux
    // produce m_write = 0 and m_wstrb = 0 for instruction grants.
    arb_req_slot #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_i_slot (
        .clk(clk), .rst(rst),
        .req_valid(i_req_valid), .req_ready(i_req_ready),
        .req_addr(i_req_addr), .req_write(1'b0),
        .req_wdata('0), .req_wstrb('0),
        .clear(clr_i), .pending(i_pend),
        .addr(i_addr_q), .write(i_wr_q), .wdata(i_wdata_q), .wstrb(i_wstrb_q)
    );

    arb_req_slot #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_d_slot (
        .clk(clk), .rst(rst),
        .req_valid(d_req_valid), .req_ready(d_req_ready),
        .req_addr(d_req_addr), .req_write(d_req_write),
        .req_wdata(d_req_wdata), .req_wstrb(d_req_wstrb),
        .clear(clr_d), .pending(d_pend),
        .addr(d_addr_q), .write(d_wr_q), .wdata(d_wdata_q), .wstrb(d_wstrb_q)
    );

    always_comb begin
        state_next  = state;
        grant_sel   = rr_pick(i_pend, d_pend, last_grant);
        do_grant    = 1'b0;
        do_resp     = 1'b0;
        do_timeout  = 1'b0;
        timeout_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);
        case (state)
            ARB_STATE_IDLE: begin
                if (i_pend || d_pend) begin
                    do_grant   = 1'b1;
                    state_next = ARB_STATE_REQ;
                end
            end
            ARB_STATE_REQ: begin
                if (timeout_hit) begin
                    do_timeout = 1'b1;
                    state_next = ARB_STATE_IDLE;
                end else if (m_req_ready) begin
                    state_next = ARB_STATE_WAIT;
                end
            end
            ARB_STATE_WAIT: begin
                // A real response beats a timeout landing in the same cycle.
                if (m_resp_valid) begin
                    do_resp    = 1'b1;
                    state_next = ARB_STATE_IDLE;
                end else if (timeout_hit) begin
                    do_timeout = 1'b1;
                    state_next = ARB_STATE_IDLE;
                end
            end
            default: state_next = ARB_STATE_IDLE;
        endcase
        clr_i = (do_resp || do_timeout) && (grant == ARB_GRANT_INST);
        clr_d = (do_resp || do_timeout) && (grant == ARB_GRANT_DATA);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ARB_STATE_IDLE;
            last_grant   <= ARB_GRANT_INST;
            grant        <= ARB_GRANT_INST;
            tmo_cnt      <= '0;
            m_req_valid  <= 1'b0;
            m_addr       <= '0;
            m_write      <= 1'b0;
            m_wdata      <= '0;
            m_wstrb      <= '0;
            i_resp_valid <= 1'b0;
            i_resp_data  <= '0;
            i_resp_error <= 1'b0;
            d_resp_valid <= 1'b0;
            d_resp_data  <= '0;
            d_resp_error <= 1'b0;
        end else begin
            state        <= state_next;
            i_resp_valid <= 1'b0;
            i_resp_error <= 1'b0;
            d_resp_valid <= 1'b0;
            d_resp_error <= 1'b0;

            if (do_grant) begin
                grant       <= grant_sel;
                last_grant  <= grant_sel;
                tmo_cnt     <= '0;
                m_req_valid <= 1'b1;
                m_addr      <= (grant_sel == ARB_GRANT_DATA) ? d_addr_q  : i_addr_q;
                m_write     <= (grant_sel == ARB_GRANT_DATA) ? d_wr_q    : i_wr_q;
                m_wdata     <= (grant_sel == ARB_GRANT_DATA) ? d_wdata_q : i_wdata_q;
                m_wstrb     <= (grant_sel == ARB_GRANT_DATA) ? d_wstrb_q : i_wstrb_q;
            end else if (state != ARB_STATE_IDLE && tmo_cnt != '1) begin
                tmo_cnt <= tmo_cnt + CNT_WIDTH'(1);
            end

            if (do_timeout || (state == ARB_STATE_REQ && m_req_ready))
                m_req_valid <= 1'b0;

            if (do_resp || do_timeout) begin
                if (grant == ARB_GRANT_DATA) begin
                    d_resp_valid <= 1'b1;
                    d_resp_error <= do_timeout;
                    d_resp_data  <= do_timeout ? '0 : m_resp_data;
                end else begin
                    i_resp_valid <= 1'b1;
                    i_resp_error <= do_timeout;
                    i_resp_data  <= do_timeout ? '0 : m_resp_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of request vectors driven through a reactive
// memory model; expected memory requests and channel responses are queued
// when stimulus is driven and popped as the DUT produces them.
module tb_mem_arbiter;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int SW     = DW / 8;
    localparam int TO_CYC = 8;

    logic          clk, rst;
    logic          i_req_valid, i_req_ready, i_resp_valid, i_resp_error;
    logic [AW-1:0] i_req_addr;
    logic [DW-1:0] i_resp_data;
    logic          d_req_valid, d_req_ready, d_req_write, d_resp_valid, d_resp_error;
    logic [AW-1:0] d_req_addr;
    logic [DW-1:0] d_req_wdata, d_resp_data;
    logic [SW-1:0] d_req_wstrb;
    logic          m_req_valid, m_req_ready, m_write, m_resp_valid;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_resp_data;
    logic [SW-1:0] m_wstrb;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data), .i_resp_error(i_resp_error),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_req_write(d_req_write), .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
        .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data), .d_resp_error(d_resp_error),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_addr(m_addr),
        .m_write(m_write), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_resp_valid(m_resp_valid), .m_resp_data(m_resp_data)
    );

    typedef struct {
        logic          iv;
        logic [31:0]   i_addr;
        logic [31:0]   i_rdata;
        logic          dv;
        logic [31:0]   d_addr;
        logic          d_write;
        logic [31:0]   d_wdata;
        logic [3:0]    d_wstrb;
        logic [31:0]   d_rdata;
        int            stall;
        int            lat;
        logic          data_first;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        int          stall;
        int          lat;
    } mreq_t;

    typedef struct {
        logic        is_data;
        logic [31:0] data;
        logic        err;
        int          lat;
    } resp_t;

    mreq_t exp_mreq[$];
    resp_t exp_resp[$];
    vec_t  vecs[11];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    mreq_t       cur;
    int          stall_left = 0;
    int          countdown = 0;
    int          seen_cyc = 0;
    logic        in_req = 1'b0;
    logic [31:0] cur_rdata = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_ev(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: event not expected (cycle %0d)", name, cyc);
    endtask

    function automatic resp_t make_resp(input logic is_data, input logic [31:0] rdata,
                                        input int stall, input int lat);
        resp_t r;
        logic  to;
        to        = (lat <= 0) || (stall + 1 + lat > TO_CYC);
        r.is_data = is_data;
        r.err     = to;
        r.data    = to ? 32'h0 : rdata;
        r.lat     = to ? TO_CYC : stall + 1 + lat;
        return r;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Response monitor and memory model, evaluated away from the active edge.
    initial forever begin
        resp_t r;
        @(negedge clk);
        if (!rst) begin
            m_req_ready  = 1'b0;
            m_resp_valid = 1'b0;
            countdown    = 0;
            in_req       = 1'b0;
        end else begin
            if (i_resp_valid && d_resp_valid) begin
                fail_ev("dual_resp");
            end else if (i_resp_valid || d_resp_valid) begin
                if (exp_resp.size() == 0) begin
                    fail_ev("unexpected_resp");
                end else begin
                    r = exp_resp.pop_front();
                    chk("resp_chan", 64'(d_resp_valid), 64'(r.is_data));
                    chk("resp_data", 64'(d_resp_valid ? d_resp_data : i_resp_data), 64'(r.data));
                    chk("resp_err", 64'(d_resp_valid ? d_resp_error : i_resp_error), 64'(r.err));
                    chk("resp_latency", 64'(cyc - seen_cyc), 64'(r.lat));
                end
            end

            m_resp_valid = 1'b0;
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    m_resp_valid = 1'b1;
                    m_resp_data  = cur_rdata;
                end
            end

            if (m_req_valid) begin
                if (!in_req && exp_mreq.size() == 0) begin
                    fail_ev("unexpected_mreq");
                    m_req_ready = 1'b1;
                end else begin
                    if (!in_req) begin
                        cur        = exp_mreq.pop_front();
                        in_req     = 1'b1;
                        stall_left = cur.stall;
                        seen_cyc   = cyc;
                    end
                    chk("m_addr", 64'(m_addr), 64'(cur.addr));
                    chk("m_write", 64'(m_write), 64'(cur.write));
                    chk("m_wstrb", 64'(m_wstrb), 64'(cur.wstrb));
                    if (cur.write) chk("m_wdata", 64'(m_wdata), 64'(cur.wdata));
                    if (stall_left > 0) begin
                        m_req_ready = 1'b0;
                        stall_left--;
                    end else begin
                        m_req_ready = 1'b1;
                        in_req      = 1'b0;
                        countdown   = (cur.lat > 0) ? cur.lat : 0;
                        cur_rdata   = cur.rdata;
                    end
                end
            end else begin
                m_req_ready = 1'b0;
            end
        end
    end

    task automatic wait_idle();
        int g = 0;
        while ((countdown != 0 || exp_resp.size() != 0 || exp_mreq.size() != 0) && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (g >= 300) fail_ev("wait_idle_bound");
        repeat (2) @(negedge clk);
    endtask

    task automatic apply_vec(input vec_t v);
        mreq_t mi, md;
        resp_t ri, rd;
        mi = '{addr: v.i_addr, write: 1'b0, wdata: 32'h0, wstrb: 4'h0,
               rdata: v.i_rdata, stall: v.stall, lat: v.lat};
        md = '{addr: v.d_addr, write: v.d_write, wdata: v.d_wdata, wstrb: v.d_wstrb,
               rdata: v.d_rdata, stall: v.stall, lat: v.lat};
        ri = make_resp(1'b0, v.i_rdata, v.stall, v.lat);
        rd = make_resp(1'b1, v.d_rdata, v.stall, v.lat);
        if (v.iv && v.dv && v.data_first) begin
            exp_mreq.push_back(md); exp_resp.push_back(rd);
            exp_mreq.push_back(mi); exp_resp.push_back(ri);
        end else begin
            if (v.iv) begin exp_mreq.push_back(mi); exp_resp.push_back(ri); end
            if (v.dv) begin exp_mreq.push_back(md); exp_resp.push_back(rd); end
        end
        @(negedge clk);
        i_req_valid = v.iv;
        i_req_addr  = v.i_addr;
        d_req_valid = v.dv;
        d_req_addr  = v.d_addr;
        d_req_write = v.d_write;
        d_req_wdata = v.d_wdata;
        d_req_wstrb = v.d_wstrb;
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        @(negedge clk);
        chk("i_ready_after_capture", 64'(i_req_ready), 64'(!v.iv));
        chk("d_ready_after_capture", 64'(d_req_ready), 64'(!v.dv));
        chk("m_valid_capture_edge", 64'(m_req_valid), 64'd0);
        @(negedge clk);
        chk("m_valid_grant_edge", 64'(m_req_valid), 64'd1);
        wait_idle();
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        vecs[0]  = '{1'b1, 32'h100, 32'h00500093, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 0, 1, 1'b0};
        vecs[1]  = '{1'b1, 32'h200, 32'h11111111, 1'b1, 32'h8000, 1'b1, 32'hDEADBEEF, 4'hF, 32'h12345678, 0, 1, 1'b1};
        vecs[2]  = '{1'b0, 32'h0, 32'h0, 1'b1, 32'h8010, 1'b0, 32'h0, 4'h0, 32'hCAFEF00D, 0, 2, 1'b0};
        vecs[3]  = '{1'b1, 32'h204, 32'h22222222, 1'b1, 32'h8014, 1'b0, 32'h0, 4'h0, 32'h33333333, 0, 1, 1'b0};
        vecs[4]  = '{1'b0, 32'h0, 32'h0, 1'b1, 32'h8020, 1'b1, 32'hA5A55A5A, 4'h5, 32'h0, 5, 1, 1'b0};
        vecs[5]  = '{1'b0, 32'h0, 32'h0, 1'b1, 32'h8030, 1'b0, 32'h0, 4'h0, 32'h44444444, 0, -1, 1'b0};
        vecs[6]  = '{1'b0, 32'h0, 32'h0, 1'b1, 32'h8034, 1'b0, 32'h0, 4'h0, 32'h55555555, 0, 9, 1'b0};
        vecs[7]  = '{1'b0, 32'h0, 32'h0, 1'b1, 32'h8038, 1'b0, 32'h0, 4'h0, 32'h66666666, 0, 7, 1'b0};
        vecs[8]  = '{1'b0, 32'h0, 32'h0, 1'b1, 32'h803C, 1'b0, 32'h0, 4'h0, 32'h77777777, 0, 8, 1'b0};
        vecs[9]  = '{1'b1, 32'h300, 32'h88888888, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 0, -1, 1'b0};
        vecs[10] = '{1'b1, 32'h304, 32'h99999999, 1'b1, 32'h8040, 1'b1, 32'h01020304, 4'hC, 32'hAAAAAAAA, 2, 1, 1'b1};

        i_req_valid = 1'b0; i_req_addr = '0;
        d_req_valid = 1'b0; d_req_addr = '0; d_req_write = 1'b0;
        d_req_wdata = '0;   d_req_wstrb = '0;
        m_req_ready = 1'b0; m_resp_valid = 1'b0; m_resp_data = '0;

        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("rst_i_ready", 64'(i_req_ready), 64'd1);
        chk("rst_d_ready", 64'(d_req_ready), 64'd1);
        chk("rst_m_valid", 64'(m_req_valid), 64'd0);
        chk("rst_m_addr", 64'(m_addr), 64'd0);
        chk("rst_m_write", 64'(m_write), 64'd0);
        chk("rst_m_wstrb", 64'(m_wstrb), 64'd0);
        chk("rst_i_resp_valid", 64'(i_resp_valid), 64'd0);
        chk("rst_d_resp_valid", 64'(d_resp_valid), 64'd0);
        chk("rst_i_resp_data", 64'(i_resp_data), 64'd0);
        chk("rst_d_resp_error", 64'(d_resp_error), 64'd0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 11; i++) apply_vec(vecs[i]);

        // Data request captured on the instruction grant edge waits its turn.
        exp_mreq.push_back('{addr: 32'h600, write: 1'b0, wdata: 32'h0, wstrb: 4'h0,
                             rdata: 32'h0BADF00D, stall: 0, lat: 1});
        exp_mreq.push_back('{addr: 32'h8200, write: 1'b1, wdata: 32'h0F0F0F0F, wstrb: 4'h3,
                             rdata: 32'h13579BDF, stall: 0, lat: 1});
        exp_resp.push_back(make_resp(1'b0, 32'h0BADF00D, 0, 1));
        exp_resp.push_back(make_resp(1'b1, 32'h13579BDF, 0, 1));
        @(negedge clk);
        i_req_valid = 1'b1; i_req_addr = 32'h600;
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        d_req_valid = 1'b1; d_req_addr = 32'h8200; d_req_write = 1'b1;
        d_req_wdata = 32'h0F0F0F0F; d_req_wstrb = 4'h3;
        @(posedge clk);
        #1 d_req_valid = 1'b0;
        @(negedge clk);
        chk("late_capture_d_ready", 64'(d_req_ready), 64'd0);
        chk("late_capture_grant_addr", 64'(m_addr), 64'h600);
        wait_idle();

        // Asynchronous reset while a fetch is stalled in REQ.
        exp_mreq.push_back('{addr: 32'h400, write: 1'b0, wdata: 32'h0, wstrb: 4'h0,
                             rdata: 32'h0, stall: 6, lat: -1});
        @(negedge clk);
        i_req_valid = 1'b1; i_req_addr = 32'h400;
        @(posedge clk);
        #1 i_req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("pre_rst_req_m_valid", 64'(m_req_valid), 64'd1);
        rst = 1'b0;
        #1;
        chk("rst_req_m_valid", 64'(m_req_valid), 64'd0);
        chk("rst_req_i_ready", 64'(i_req_ready), 64'd1);
        @(negedge clk);
        #1 rst = 1'b1;
        exp_mreq.delete();
        repeat (12) @(negedge clk);

        // Asynchronous reset mid-WAIT with the instruction slot still queued.
        exp_mreq.push_back('{addr: 32'h8100, write: 1'b0, wdata: 32'h0, wstrb: 4'h0,
                             rdata: 32'h0, stall: 0, lat: -1});
        @(negedge clk);
        i_req_valid = 1'b1; i_req_addr = 32'h500;
        d_req_valid = 1'b1; d_req_addr = 32'h8100; d_req_write = 1'b0; d_req_wstrb = 4'h0;
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_rst_wait_i_ready", 64'(i_req_ready), 64'd0);
        chk("pre_rst_wait_d_ready", 64'(d_req_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_wait_i_ready", 64'(i_req_ready), 64'd1);
        chk("rst_wait_d_ready", 64'(d_req_ready), 64'd1);
        chk("rst_wait_m_valid", 64'(m_req_valid), 64'd0);
        chk("rst_wait_resp", 64'({i_resp_valid, d_resp_valid}), 64'd0);
        @(negedge clk);
        #1 rst = 1'b1;
        exp_mreq.delete();
        repeat (12) @(negedge clk);

        apply_vec('{1'b1, 32'h700, 32'h00A00113, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 0, 2, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
